// File: rtl/count_sequencer_if.sv
// Control/status bundle between a counter sequencer and its user.
// Carries the start/stop/pause/reload controls and the count status.
interface count_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] reload_cnt;

  modport master (
    output start,
    output stop,
    output pause,
    output reload,
    output load_val,
    input  q,
    input  busy,
    input  done,
    input  reload_cnt
  );

  modport slave (
    input  start,
    input  stop,
    input  pause,
    input  reload,
    input  load_val,
    output q,
    output busy,
    output done,
    output reload_cnt
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer for a WIDTH-bit down-counter: one-shot/auto-reload, pause, stop.
// Define CNT_PRESCALE_EN to tick once every PRESCALE cycles instead of every cycle.
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic clr,
  count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] load_reg;
  logic [WIDTH-1:0] rcnt;
  logic             busy;
  logic             done;
  logic             tick;
  logic             last;

  generate
    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
      $error("PRESCALE must be within 2..256");
    end
  endgenerate

`ifdef CNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] psc;
  logic          psc_clr;
  logic          psc_run;

  // Held at zero outside RUN so every start/reload begins a full interval.
  assign psc_clr = (state != RUN) || bus.stop;
  assign psc_run = (state == RUN) && !bus.pause;
  assign tick    = (psc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      psc <= '0;
    end else if (psc_clr) begin
      psc <= '0;
    end else if (psc_run) begin
      psc <= tick ? '0 : psc + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign last = (q == WIDTH'(1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      q        <= '0;
      load_reg <= '0;
      rcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            load_reg <= bus.load_val;
            q        <= bus.load_val;
            rcnt     <= '0;
            busy     <= 1'b1;
            if (bus.load_val == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (!bus.pause && tick && q != '0) begin
            q <= q - WIDTH'(1);
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (bus.reload) begin
            q <= load_reg;
            if (!(&rcnt)) begin
              rcnt <= rcnt + WIDTH'(1);
            end
            // A zero reload value terminates immediately again.
            if (load_reg == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q          = q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.reload_cnt = rcnt;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed scoreboard bench for count_sequencer.
// Expected {q,busy,done,reload_cnt} is queued per step and checked after the edge.
module tb_count_sequencer;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [W-1:0] rc;
  } exp_t;

  logic clk;
  logic clr;
  int   errors;
  int   checks;
  exp_t sb[$];

  count_sequencer_if #(.WIDTH(W)) bus ();

  count_sequencer #(
    .WIDTH    (W),
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [W-1:0] eq, input logic eb,
                      input logic ed, input logic [W-1:0] er);
    exp_t e;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    e.rc   = er;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    exp_t o;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      o = {bus.q, bus.busy, bus.done, bus.reload_cnt};
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed q=%0d busy=%b done=%b rc=%0d required q=%0d busy=%b done=%b rc=%0d",
               tag, o.q, o.busy, o.done, o.rc, e.q, e.busy, e.done, e.rc);
      end
    end
  endtask

  task automatic step(input logic [W-1:0] eq, input logic eb,
                      input logic ed, input logic [W-1:0] er,
                      input string tag);
    push(eq, eb, ed, er);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    logic [W-1:0] rc;
    logic [W-1:0] rc_prev;
    errors       = 0;
    checks       = 0;
    clk          = 1'b0;
    clr          = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.reload   = 1'b0;
    bus.load_val = '0;
    #12;
    push(0, 0, 0, 0);
    chk("reset");
    clr = 1'b1;
    @(posedge clk);
    #1;

`ifndef CNT_PRESCALE_EN
    // one-shot, L=3
    bus.load_val = 4'd3;
    bus.start    = 1'b1;
    step(3, 1, 0, 0, "os_load");
    bus.start = 1'b0;
    step(2, 1, 0, 0, "os_2");
    step(1, 1, 0, 0, "os_1");
    step(0, 1, 1, 0, "os_done");
    step(0, 0, 0, 0, "os_idle");

    // pause, ignored start, stop
    bus.load_val = 4'd9;
    bus.start    = 1'b1;
    step(9, 1, 0, 0, "ps_load");
    bus.load_val = 4'd2;
    step(8, 1, 0, 0, "ps_start_ign");
    bus.start = 1'b0;
    step(7, 1, 0, 0, "ps_7");
    step(6, 1, 0, 0, "ps_6");
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) step(6, 1, 0, 0, "ps_hold");
    bus.pause = 1'b0;
    step(5, 1, 0, 0, "ps_5");
    step(4, 1, 0, 0, "ps_4");
    bus.stop = 1'b1;
    step(4, 0, 0, 0, "stop_idle");
    bus.stop = 1'b0;
    step(4, 0, 0, 0, "stop_nodone");

    // auto-reload L=2 with reload_cnt saturation
    bus.load_val = 4'd2;
    bus.reload   = 1'b1;
    bus.start    = 1'b1;
    step(2, 1, 0, 0, "ar_load");
    bus.start = 1'b0;
    rc_prev = '0;
    for (int k = 1; k <= 17; k++) begin
      step(1, 1, 0, rc_prev, "ar_1");
      step(0, 1, 1, rc_prev, "ar_done");
      rc = (k > 15) ? 4'd15 : 4'(k);
      step(2, 1, 0, rc, "ar_reload");
      rc_prev = rc;
    end
    bus.reload = 1'b0;
    step(1, 1, 0, 15, "ar_end_1");
    step(0, 1, 1, 15, "ar_end_done");
    step(0, 0, 0, 15, "ar_end_idle");

    // zero load value
    bus.load_val = 4'd0;
    bus.start    = 1'b1;
    step(0, 1, 1, 0, "zero_done");
    bus.start = 1'b0;
    step(0, 0, 0, 0, "zero_idle");

    // start+stop in IDLE
    bus.load_val = 4'd7;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    step(0, 0, 0, 0, "ss_idle");
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step(0, 0, 0, 0, "ss_idle2");

    // asynchronous clear mid-run
    bus.load_val = 4'd8;
    bus.start    = 1'b1;
    step(8, 1, 0, 0, "ac_load");
    bus.start = 1'b0;
    step(7, 1, 0, 0, "ac_7");
    step(6, 1, 0, 0, "ac_6");
    step(5, 1, 0, 0, "ac_5");
    #2;
    clr = 1'b0;
    #1;
    push(0, 0, 0, 0);
    chk("async_clr");
    #2;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "ac_nodone");
`else
    // prescaled count, PRESCALE=4, L=2
    bus.load_val = 4'd2;
    bus.start    = 1'b1;
    step(2, 1, 0, 0, "pre_load");
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) step(2, 1, 0, 0, "pre_hold_a");
    step(1, 1, 0, 0, "pre_e4");
    for (int i = 5; i <= 7; i++) step(1, 1, 0, 0, "pre_hold_b");
    step(0, 1, 1, 0, "pre_e8_done");
    step(0, 0, 0, 0, "pre_idle");

    // same with a 2-cycle pause mid-interval
    bus.start = 1'b1;
    step(2, 1, 0, 0, "prp_load");
    bus.start = 1'b0;
    step(2, 1, 0, 0, "prp_e1");
    step(2, 1, 0, 0, "prp_e2");
    bus.pause = 1'b1;
    step(2, 1, 0, 0, "prp_e3");
    step(2, 1, 0, 0, "prp_e4");
    bus.pause = 1'b0;
    step(2, 1, 0, 0, "prp_e5");
    step(1, 1, 0, 0, "prp_e6");
    for (int i = 7; i <= 9; i++) step(1, 1, 0, 0, "prp_hold");
    step(0, 1, 1, 0, "prp_e10_done");
    step(0, 0, 0, 0, "prp_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
